// File: rtl/serial_scan_receiver.sv
// Receiving end of the scanner serial link: synchronizes the remote bit clock/data,
// packs bits MSB-first into words and buffers one frame for in-order readout.
module serial_scan_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS      = 16,
  parameter int ADDR_W     = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  serialClk,
  input  logic                  serialIn,
  output logic                  startRead,
  input  logic                  rdEn,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  rdValid,
  output logic [ADDR_W:0]       wordCount,
  output logic                  busy,
  output logic                  done,
  output logic                  timeoutErr
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(WORDS - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_RECEIVE, S_DONE} state_t;

  state_t                state_q;
  logic                  sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic                  sin_s1_q, sin_s2_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [TMR_W-1:0]      timer_q;
  logic                  wr_pend_q;
  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]       count_q, frame_cnt_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q, start_read_q, busy_q, done_q, timeout_err_q;
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic rise, rd_fire, wr_fire;

  assign rise    = sclk_s2_q & ~sclk_prev_q;
  assign rd_fire = rdEn && (count_q != '0);
  assign wr_fire = wr_pend_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sin_s1_q    <= 1'b0;
      sin_s2_q    <= 1'b0;
    end else begin
      sclk_s1_q   <= serialClk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sin_s1_q    <= serialIn;
      sin_s2_q    <= sin_s1_q;
    end
  end

  // Buffer storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      wr_pend_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_cnt_q   <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      start_read_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_pend_q  <= 1'b0;
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      if (wr_fire) begin
        wr_ptr_q    <= wr_ptr_q + 1'b1;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (wr_fire && !rd_fire)      count_q <= count_q + 1'b1;
      else if (rd_fire && !wr_fire) count_q <= count_q - 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q       <= S_REQUEST;
            start_read_q  <= 1'b1;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_cnt_q   <= '0;
            bit_cnt_q     <= '0;
            timer_q       <= TMR_LOAD;
          end
        end
        S_REQUEST: begin
          if (rise) begin
            state_q   <= S_RECEIVE;
            shift_q   <= {shift_q[DATA_WIDTH-2:0], sin_s2_q};
            bit_cnt_q <= BIT_W'(1);
            timer_q   <= TMR_LOAD;
          end else if (timer_q <= TMR_W'(1)) begin
            state_q       <= S_IDLE;
            start_read_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_RECEIVE: begin
          // A write cycle always follows a rise, so it never coincides with a rise or timeout.
          if (wr_fire && frame_cnt_q == LAST_WORD) begin
            state_q      <= S_DONE;
            start_read_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else if (rise) begin
            shift_q <= {shift_q[DATA_WIDTH-2:0], sin_s2_q};
            timer_q <= TMR_LOAD;
            if (bit_cnt_q == LAST_BIT) begin
              wr_pend_q <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (timer_q <= TMR_W'(1)) begin
            state_q       <= S_IDLE;
            start_read_q  <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_DONE: begin
          if (!start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign startRead  = start_read_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeoutErr = timeout_err_q;
  assign rdData     = rd_data_q;
  assign rdValid    = rd_valid_q;
  assign wordCount  = count_q;

endmodule
